bram_sd_sequencer: RTL and testbench
====================================

Name: bram_sd_sequencer

Overview:
- Controller for the backup-RAM (BRAM) host port.
- Sequences 16-sector load/save transfers of the save image over the HPS SD sector handshake.
- Runs the "Format Save" default-header writer.
- Arbitrates the BRAM port B between the SD buffer path and the format writer. The core keeps port A; `loading` is OR'd into the core reset by the top level.

Parameters:
- SLOT_W, 2, width of save-slot select.
- SEC_W, 4, log2 of sectors per slot (16 sectors of 512 B).
- ADDR_W, 12, BRAM port-B word address width (= SEC_W + 8).
- TIMEOUT, 24'd5_000_000, clk_sys cycles allowed waiting for sd_ack edges (optional feature only).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- bk_ena  in  1  writable save image mounted
- load_req  in  1  OSD load level; rising edge starts load
- save_req  in  1  OSD save level; rising edge starts save
- format_req  in  1  OSD format level; rising edge starts format
- slot  in  SLOT_W  save slot, sampled at start
- sd_lba  out  32  sector address to HPS
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  HPS transfer acknowledge (high for whole sector)
- sd_buff_addr  in  8  word index within sector
- sd_buff_dout  in  16  word from HPS
- sd_buff_wr  in  1  HPS word write strobe
- bram_b_addr  out  ADDR_W  port-B address
- bram_b_data  out  16  port-B write data
- bram_b_we  out  1  port-B write enable
- busy  out  1  transfer or format in progress
- loading  out  1  load in progress (hold core in reset)
- err  out  1  sticky timeout flag (0 when feature off)

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; sd_rd=sd_wr=0, sd_lba=0, busy=loading=err=0, bram_b_we=0. Edge-detect registers are loaded with the current input levels, so a level already high at reset release does not trigger.
- Edges are detected with one registered stage per request input.
- IDLE:
  - Load/save edge with bk_ena=1 → REQ next cycle.
    - sd_lba = {zeros, slot, SEC_W'0}, i.e. slot*16.
    - loading = load edge.
    - sd_rd = load, sd_wr = ~load.
    - busy = 1.
  - Load and save edges in the same cycle: load wins.
  - Load/save edge with bk_ena=0: ignored.
  - Format edge: → FORMAT, only if no load/save edge is accepted in the same cycle; otherwise the format edge is discarded.
- REQ: the first cycle sd_ack is sampled high, clear sd_rd/sd_wr (registered) → XFER.
- XFER: on sd_ack falling:
  - If sd_lba[SEC_W-1:0] is all ones → IDLE; clear loading and busy.
  - Otherwise increment sd_lba by 1 and reassert the same request next cycle → REQ.
- FORMAT: write 4 words over 4 consecutive cycles, then → IDLE with busy=0:
  - addr 0 = 16'h5548
  - addr 1 = 16'h4D42
  - addr 2 = 16'h8800
  - addr 3 = 16'h8010
- Port-B mux:
  - In FORMAT: addr/data from the format counter/table; we=1.
  - Otherwise: addr = {sd_lba[SEC_W-1:0], sd_buff_addr}; data = sd_buff_dout; we = sd_buff_wr & sd_ack & loading (combinational, zero latency).
  - Save reads port-B q externally; this block never writes during save.
- All edges arriving while busy are ignored; they are not queued.
- bk_ena falling mid-transfer does not abort; only reset_n aborts. Abort → IDLE with all requests deasserted in the same edge.
- sd_lba wraps only within the low SEC_W bits; slot bits never change during a transfer.

Optional Feature:
- Macro: BRAM_SD_TIMEOUT_EN.
- Defined:
  - A 24-bit watchdog runs in REQ/XFER and clears on every sd_ack edge.
  - At TIMEOUT it forces IDLE: sd_rd=sd_wr=0, loading=busy=0, err=1.
  - err clears only on reset or on the next accepted load/save edge.
- Undefined: no counter; err tied 0; the controller waits indefinitely.

Decomposition:
- Package bram_sd_pkg:
  - state enum {IDLE, REQ, XFER, FORMAT}
  - FMT_WORDS=4
  - format default table (4×16-bit localparam array)
  - SEC_PER_SLOT
- One sub-module, bram_sd_edge: a generic rising-edge detector, instanced ×3 for load/save/format.

Test Plan:
- Load, slot=2, bk_ena=1; HPS model acks 16 sectors, each with 256 sd_buff_wr strobes → sd_lba steps 32..47; sd_rd reasserts each sector; port-B receives 4096 writes at addr {sec,idx}; loading/busy fall one cycle after the 16th ack fall.
- Save, slot=0 → sd_wr pulses 16 times, sd_lba 0..15; bram_b_we never asserts; sd_rd stays 0.
- Format edge in IDLE → exactly 4 we cycles with addr 0..3 and data 5548/4D42/8800/8010; busy high for 4 cycles.
- Load and save edges in the same cycle with format also high, bk_ena=1 → load runs, format discarded; a second save edge mid-load is ignored. Also, a load edge with bk_ena=0 → no sd_rd, busy stays 0.
- reset_n low during sector 5 of a load → next edge: sd_rd=0, sd_lba=0, loading=0, state IDLE; with load_req held high across reset release, no new load starts.
- With BRAM_SD_TIMEOUT_EN and TIMEOUT=100, save with the HPS never acking → after 100 cycles sd_wr=0, busy=0, err=1; the next save edge clears err.

Source files
------------

// File: rtl/bram_sd_pkg.sv
// Shared types and constants for the backup-RAM SD sequencer.
// FSM states, format header table and slot geometry.
package bram_sd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    FORMAT
  } state_t;

  localparam int FMT_WORDS    = 4;
  localparam int SEC_PER_SLOT = 16;

  // Default save header written by "Format Save", word-addressed from 0.
  localparam logic [15:0] FMT_TABLE [FMT_WORDS] = '{
    16'h5548,
    16'h4D42,
    16'h8800,
    16'h8010
  };

endpackage

// File: rtl/bram_sd_edge.sv
// Rising-edge detector with one registered stage.
// Reset loads the current level so a held level never fires.
module bram_sd_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic lvl,
  output logic rise
);

  logic prev;

  // Track the previous level; reset captures the live level.
  always_ff @(posedge clk) begin
    prev <= lvl;
  end

  assign rise = lvl & ~prev & reset_n;

endmodule

// File: rtl/bram_sd_sequencer.sv
// BRAM host-port controller: SD sector load/save, format writer, port-B mux.
// Optional watchdog enabled with `define BRAM_SD_TIMEOUT_EN.
import bram_sd_pkg::*;

module bram_sd_sequencer #(
  parameter int          SLOT_W  = 2,
  parameter int          SEC_W   = 4,
  parameter int          ADDR_W  = 12,
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              bk_ena,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic [SLOT_W-1:0] slot,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [7:0]        sd_buff_addr,
  input  logic [15:0]       sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [ADDR_W-1:0] bram_b_addr,
  output logic [15:0]       bram_b_data,
  output logic              bram_b_we,
  output logic              busy,
  output logic              loading,
  output logic              err
);

  logic   load_rise;
  logic   save_rise;
  logic   fmt_rise;
  state_t state;
  logic   [1:0] fmt_cnt;
  logic   ack_q;
  logic   accept;
  logic   ack_fall;
  logic   lba_last;
  logic   [31:0] lba_base;

  bram_sd_edge u_load_edge (
    .clk     (clk_sys),
    .reset_n (reset_n),
    .lvl     (load_req),
    .rise    (load_rise)
  );

  bram_sd_edge u_save_edge (
    .clk     (clk_sys),
    .reset_n (reset_n),
    .lvl     (save_req),
    .rise    (save_rise)
  );

  bram_sd_edge u_fmt_edge (
    .clk     (clk_sys),
    .reset_n (reset_n),
    .lvl     (format_req),
    .rise    (fmt_rise)
  );

  assign accept   = (state == IDLE) & bk_ena & (load_rise | save_rise);
  assign ack_fall = ack_q & ~sd_ack;
  assign lba_last = sd_lba[SEC_W-1:0] == SEC_W'(SEC_PER_SLOT - 1);
  assign lba_base = {{(32-SLOT_W-SEC_W){1'b0}}, slot, {SEC_W{1'b0}}};

`ifdef BRAM_SD_TIMEOUT_EN
  logic [23:0] wdog;
  logic        ack_edge;
  assign ack_edge = ack_q ^ sd_ack;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  // Sequencer FSM; all handshake and status outputs are registered.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= IDLE;
      fmt_cnt <= '0;
      ack_q   <= 1'b0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      busy    <= 1'b0;
      loading <= 1'b0;
`ifdef BRAM_SD_TIMEOUT_EN
      wdog    <= '0;
      err     <= 1'b0;
`endif
    end else begin
      ack_q <= sd_ack;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= REQ;
            sd_lba  <= lba_base;
            loading <= load_rise;
            sd_rd   <= load_rise;
            sd_wr   <= ~load_rise;
            busy    <= 1'b1;
          end else if (fmt_rise) begin
            state   <= FORMAT;
            fmt_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end
        end
        XFER: begin
          if (ack_fall) begin
            if (lba_last) begin
              state   <= IDLE;
              loading <= 1'b0;
              busy    <= 1'b0;
            end else begin
              sd_lba[SEC_W-1:0] <= sd_lba[SEC_W-1:0] + 1'b1;
              sd_rd <= loading;
              sd_wr <= ~loading;
              state <= REQ;
            end
          end
        end
        FORMAT: begin
          fmt_cnt <= fmt_cnt + 1'b1;
          if (fmt_cnt == 2'(FMT_WORDS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef BRAM_SD_TIMEOUT_EN
      if (accept) begin
        err <= 1'b0;
      end
      if (state == REQ || state == XFER) begin
        if (ack_edge) begin
          wdog <= '0;
        end else if (wdog == TIMEOUT - 24'd1) begin
          wdog    <= '0;
          state   <= IDLE;
          sd_rd   <= 1'b0;
          sd_wr   <= 1'b0;
          loading <= 1'b0;
          busy    <= 1'b0;
          err     <= 1'b1;
        end else begin
          wdog <= wdog + 24'd1;
        end
      end else begin
        wdog <= '0;
      end
`endif
    end
  end

  // Port-B mux: format writer owns the port, else the SD buffer path.
  always_comb begin
    bram_b_addr = ADDR_W'({sd_lba[SEC_W-1:0], sd_buff_addr});
    bram_b_data = sd_buff_dout;
    bram_b_we   = sd_buff_wr & sd_ack & loading;
    if (state == FORMAT) begin
      bram_b_addr = ADDR_W'(fmt_cnt);
      bram_b_data = FMT_TABLE[fmt_cnt];
      bram_b_we   = 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_sd_sequencer.sv
// Directed self-checking bench for bram_sd_sequencer.
// Watchdog scenario runs when BRAM_SD_TIMEOUT_EN is defined.
module tb_bram_sd_sequencer;

`ifdef BRAM_SD_TIMEOUT_EN
  localparam int WORDS = 64;
`else
  localparam int WORDS = 256;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        bk_ena;
  logic        load_req;
  logic        save_req;
  logic        format_req;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [11:0] bram_b_addr;
  logic [15:0] bram_b_data;
  logic        bram_b_we;
  logic        busy;
  logic        loading;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  bram_sd_sequencer #(
    .SLOT_W  (2),
    .SEC_W   (4),
    .ADDR_W  (12),
    .TIMEOUT (24'd100)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .bk_ena       (bk_ena),
    .load_req     (load_req),
    .save_req     (save_req),
    .format_req   (format_req),
    .slot         (slot),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .bram_b_addr  (bram_b_addr),
    .bram_b_data  (bram_b_data),
    .bram_b_we    (bram_b_we),
    .busy         (busy),
    .loading      (loading),
    .err          (err)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // HPS model for one sector: wait for request, ack, stream words, drop ack.
  task automatic run_sector(input bit is_load, input logic [31:0] exp_lba,
                            input bit last);
    bit          seen;
    int          ok_w;
    logic [7:0]  ia;
    logic [15:0] d;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (sd_rd | sd_wr) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen || sd_rd !== is_load || sd_wr !== !is_load
        || sd_lba !== exp_lba) begin
      bad++;
      $display("FAIL sector_req lba=%0d rd=%b wr=%b want lba=%0d rd=%b wr=%b",
               sd_lba, sd_rd, sd_wr, exp_lba, is_load, !is_load);
    end
    sd_ack = 1'b1;
    step();
    ok_w = 0;
    for (int i = 0; i < WORDS; i++) begin
      ia = 8'(i);
      d = 16'(exp_lba * 7 + i * 3) ^ 16'hA5A5;
      sd_buff_addr = ia;
      sd_buff_dout = d;
      sd_buff_wr = 1'b1;
      #1;
      if (bram_b_we === is_load && bram_b_addr === {exp_lba[3:0], ia}
          && (!is_load || bram_b_data === d))
        ok_w++;
      step();
    end
    sd_buff_wr = 1'b0;
    total++;
    if (ok_w != WORDS || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
      bad++;
      $display("FAIL sector_words lba=%0d good=%0d want=%0d rd=%b wr=%b",
               exp_lba, ok_w, WORDS, sd_rd, sd_wr);
    end
    sd_ack = 1'b0;
    step();
    total++;
    if (last) begin
      if (busy !== 1'b0 || loading !== 1'b0 || sd_rd !== 1'b0
          || sd_wr !== 1'b0) begin
        bad++;
        $display("FAIL sector_done busy=%b loading=%b rd=%b wr=%b want 0000",
                 busy, loading, sd_rd, sd_wr);
      end
    end else begin
      if (busy !== 1'b1 || loading !== is_load || sd_rd !== is_load
          || sd_wr !== !is_load) begin
        bad++;
        $display("FAIL sector_next busy=%b loading=%b rd=%b wr=%b want 1 %b %b %b",
                 busy, loading, sd_rd, sd_wr, is_load, is_load, !is_load);
      end
    end
  endtask

  task automatic run_transfer(input bit is_load, input logic [1:0] s);
    for (int k = 0; k < 16; k++)
      run_sector(is_load, {26'd0, s, 4'(k)}, k == 15);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++;
    if ({sd_rd, sd_wr, busy, loading, err, bram_b_we} !== 6'b0
        || sd_lba !== 32'd0) begin
      bad++;
      $display("FAIL reset_state flags=%b lba=%0d want 000000 lba=0",
               {sd_rd, sd_wr, busy, loading, err, bram_b_we}, sd_lba);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    slot = 2'd2;
    load_req = 1'b1;
    run_transfer(1'b1, 2'd2);
    load_req = 1'b0;
    step();
  endtask

  task automatic test_save();
    slot = 2'd0;
    save_req = 1'b1;
    run_transfer(1'b0, 2'd0);
    save_req = 1'b0;
    step();
  endtask

  task automatic test_format();
    logic [15:0] exp_fmt [4];
    exp_fmt = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
    format_req = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bram_b_we !== 1'b1 || bram_b_addr !== 12'(k)
          || bram_b_data !== exp_fmt[k] || busy !== 1'b1) begin
        bad++;
        $display("FAIL format_word%0d we=%b addr=%h data=%h busy=%b want 1 %h %h 1",
                 k, bram_b_we, bram_b_addr, bram_b_data, busy, k, exp_fmt[k]);
      end
      step();
    end
    total++;
    if (busy !== 1'b0 || bram_b_we !== 1'b0) begin
      bad++;
      $display("FAIL format_end busy=%b we=%b want 0 0", busy, bram_b_we);
    end
    format_req = 1'b0;
    step();
  endtask

  task automatic test_conflict();
    int extra_we;
    slot = 2'd1;
    load_req = 1'b1;
    save_req = 1'b1;
    format_req = 1'b1;
    step();
    save_req = 1'b0;
    step();
    save_req = 1'b1;
    run_transfer(1'b1, 2'd1);
    extra_we = 0;
    for (int k = 0; k < 4; k++) begin
      if (bram_b_we !== 1'b0 || busy !== 1'b0) extra_we++;
      step();
    end
    total++;
    if (extra_we != 0) begin
      bad++;
      $display("FAIL conflict_fmt_dropped active_cycles=%0d want 0", extra_we);
    end
    load_req = 1'b0;
    save_req = 1'b0;
    format_req = 1'b0;
    step();
  endtask

  task automatic test_bk_disabled();
    bk_ena = 1'b0;
    load_req = 1'b1;
    step();
    step();
    step();
    total++;
    if (sd_rd !== 1'b0 || busy !== 1'b0 || loading !== 1'b0) begin
      bad++;
      $display("FAIL bk_disabled rd=%b busy=%b loading=%b want 0 0 0",
               sd_rd, busy, loading);
    end
    load_req = 1'b0;
    bk_ena = 1'b1;
    step();
  endtask

  task automatic test_abort();
    slot = 2'd3;
    load_req = 1'b1;
    for (int k = 0; k < 5; k++)
      run_sector(1'b1, 32'd48 + 32'(k), 1'b0);
    total++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'd53) begin
      bad++;
      $display("FAIL abort_sec5 rd=%b lba=%0d want 1 53", sd_rd, sd_lba);
    end
    sd_ack = 1'b1;
    step();
    sd_buff_wr = 1'b1;
    sd_buff_addr = 8'd0;
    step();
    step();
    reset_n = 1'b0;
    step();
    total++;
    if (sd_rd !== 1'b0 || sd_lba !== 32'd0 || loading !== 1'b0
        || busy !== 1'b0 || bram_b_we !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset rd=%b lba=%0d loading=%b busy=%b we=%b want 0 0 0 0 0",
               sd_rd, sd_lba, loading, busy, bram_b_we);
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    total++;
    if (sd_rd !== 1'b0 || busy !== 1'b0 || loading !== 1'b0) begin
      bad++;
      $display("FAIL abort_held_level rd=%b busy=%b loading=%b want 0 0 0",
               sd_rd, busy, loading);
    end
    load_req = 1'b0;
    step();
  endtask

`ifdef BRAM_SD_TIMEOUT_EN
  task automatic test_timeout();
    slot = 2'd0;
    save_req = 1'b1;
    step();
    for (int k = 0; k < 99; k++) step();
    total++;
    if (sd_wr !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early wr=%b busy=%b err=%b want 1 1 0",
               sd_wr, busy, err);
    end
    step();
    total++;
    if (sd_wr !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fire wr=%b busy=%b err=%b want 0 0 1",
               sd_wr, busy, err);
    end
    save_req = 1'b0;
    step();
    save_req = 1'b1;
    step();
    total++;
    if (err !== 1'b0 || sd_wr !== 1'b1) begin
      bad++;
      $display("FAIL timeout_clear err=%b wr=%b want 0 1", err, sd_wr);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    save_req = 1'b0;
    step();
  endtask
`else
  task automatic test_no_err();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_tied err=%b want 0", err);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    bk_ena = 1'b1;
    load_req = 1'b0;
    save_req = 1'b0;
    format_req = 1'b0;
    slot = 2'd0;
    sd_ack = 1'b0;
    sd_buff_addr = 8'd0;
    sd_buff_dout = 16'd0;
    sd_buff_wr = 1'b0;
    test_reset();
    test_load();
    test_save();
    test_format();
    test_conflict();
    test_bk_disabled();
    test_abort();
`ifdef BRAM_SD_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
